// File: rtl/fht_pkg.sv
// Shared FSM encoding and sizing helpers for the FHT stage controller.
package fht_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } fht_state_t;

    // Words per bank for a given bank address width (BANK_WORDS = 2^A_BIT).
    function automatic int unsigned bank_words(input int unsigned a_bit);
        return 32'd1 << a_bit;
    endfunction

    // Number of sector bits live in a stage: min(stage, a_bit).
    function automatic int unsigned sect_bits(input int unsigned stage, input int unsigned a_bit);
        return (stage < a_bit) ? stage : a_bit;
    endfunction

endpackage

// File: rtl/fht_delay_line.sv
// Fixed-depth shift register, DEPTH cycles of latency, cleared by async reset.
// No backpressure: advances every cycle.
module fht_delay_line #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [WIDTH-1:0] src_dat,
    output logic [WIDTH-1:0] dly_dat
);

    logic [WIDTH-1:0] tap [DEPTH];

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < DEPTH; i++) tap[i] <= '0;
        end else begin
            tap[0] <= src_dat;
            for (int i = 1; i < DEPTH; i++) tap[i] <= tap[i-1];
        end
    end

    assign dly_dat = tap[DEPTH-1];

endmodule

// File: rtl/fht_stage_ctrl.sv
// Sequences all FHT stages: read sweep, drain, bank swap; outputs lag FSM state by one cycle.
// No backpressure: once started the transform runs to completion; iSTART only seen in IDLE.
module fht_stage_ctrl
    import fht_pkg::*;
#(
    parameter int A_BIT      = 8,
    parameter int STAGE_BIT  = 4,
    parameter int LAST_STAGE = A_BIT + 1,
    parameter int PIPE       = 4
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iSTART,
    output logic                 oBUSY,
    output logic                 oDONE,
    output logic                 oST_ZERO,
    output logic [A_BIT-1:0]     oSECTOR,
    output logic [A_BIT-1:0]     oROM_ADDR,
    output logic                 oRD_EN,
    output logic [A_BIT-1:0]     oRD_ADDR,
    output logic                 oWR_EN,
    output logic [A_BIT-1:0]     oWR_ADDR,
    output logic                 oBANK_SEL,
    output logic [STAGE_BIT-1:0] oSTAGE
);

    localparam int unsigned          BANK_WORDS = bank_words(A_BIT);
    localparam logic [A_BIT-1:0]     LAST_CNT   = A_BIT'(BANK_WORDS - 1);
    localparam logic [A_BIT-1:0]     ALL_ONES   = '1;
    localparam logic [STAGE_BIT-1:0] LAST_STG   = STAGE_BIT'(LAST_STAGE);
    localparam int                   DW         = $clog2(PIPE + 1);
    localparam logic [DW-1:0]        DRAIN_LOAD = DW'(PIPE);

    fht_state_t           state;
    logic [A_BIT-1:0]     cnt;
    logic [DW-1:0]        drain_cnt;
    logic [STAGE_BIT-1:0] stage;
    logic                 bank_sel;

    int unsigned          sb;
    logic [A_BIT-1:0]     sector_nxt;
    logic [A_BIT-1:0]     rom_nxt;
    logic [A_BIT:0]       wr_tap;

    // Later stages widen the sector mask one bit per stage; the ROM stride shrinks to match.
    always_comb begin
        sb         = sect_bits(32'(stage), A_BIT);
        sector_nxt = cnt & (ALL_ONES >> (A_BIT - sb));
        rom_nxt    = sector_nxt << (A_BIT - sb);
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            drain_cnt <= '0;
            stage     <= '0;
            bank_sel  <= 1'b0;
            oBUSY     <= 1'b0;
            oDONE     <= 1'b0;
            oST_ZERO  <= 1'b0;
            oSECTOR   <= '0;
            oROM_ADDR <= '0;
            oRD_EN    <= 1'b0;
            oRD_ADDR  <= '0;
            oBANK_SEL <= 1'b0;
            oSTAGE    <= '0;
        end else begin
            oBUSY     <= (state == ST_READ) || (state == ST_DRAIN);
            oDONE     <= 1'b0;
            oRD_EN    <= 1'b0;
            oST_ZERO  <= 1'b0;
            oSTAGE    <= stage;
            oBANK_SEL <= bank_sel;
            case (state)
                ST_IDLE: begin
                    if (iSTART) begin
                        state     <= ST_READ;
                        cnt       <= '0;
                        stage     <= '0;
                        bank_sel  <= 1'b0;
                        oSTAGE    <= '0;
                        oBANK_SEL <= 1'b0;
                    end
                end
                ST_READ: begin
                    oRD_EN    <= 1'b1;
                    oRD_ADDR  <= cnt;
                    oST_ZERO  <= (stage == '0);
                    oSECTOR   <= sector_nxt;
                    oROM_ADDR <= rom_nxt;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    // Hold reads off until the stage's last write has landed.
                    if (drain_cnt == DW'(1)) begin
                        if (stage == LAST_STG) begin
                            state <= ST_FINISH;
                        end else begin
                            stage    <= stage + 1'b1;
                            bank_sel <= ~bank_sel;
                            cnt      <= '0;
                            state    <= ST_READ;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_FINISH: begin
                    oDONE <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Write-back mirrors the read stream, delayed by the mixer+butterfly depth.
    fht_delay_line #(
        .WIDTH (A_BIT + 1),
        .DEPTH (PIPE)
    ) u_wr_dly (
        .iCLK    (iCLK),
        .iRESET  (iRESET),
        .src_dat ({oRD_EN, oRD_ADDR}),
        .dly_dat (wr_tap)
    );

    assign oWR_EN   = wr_tap[A_BIT];
    assign oWR_ADDR = wr_tap[A_BIT-1:0];

endmodule

// File: tb/tb_fht_stage_ctrl.sv
// Bench for fht_stage_ctrl: directed vector table, reset/back-to-back sequences, random starts vs model.
module tb_fht_stage_ctrl;

    localparam int A_BIT      = 3;
    localparam int STAGE_BIT  = 4;
    localparam int LAST_STAGE = 4;
    localparam int PIPE       = 2;
    localparam int W          = 1 << A_BIT;
    localparam int PER        = W + PIPE;
    localparam int BUSY_CYC   = (LAST_STAGE + 1) * PER;
    localparam int NV         = 21;

    logic                 iCLK, iRESET, iSTART;
    logic                 oBUSY, oDONE, oST_ZERO, oRD_EN, oWR_EN, oBANK_SEL;
    logic [A_BIT-1:0]     oSECTOR, oROM_ADDR, oRD_ADDR, oWR_ADDR;
    logic [STAGE_BIT-1:0] oSTAGE;

    fht_stage_ctrl #(
        .A_BIT(A_BIT), .STAGE_BIT(STAGE_BIT), .LAST_STAGE(LAST_STAGE), .PIPE(PIPE)
    ) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
        .oBUSY(oBUSY), .oDONE(oDONE), .oST_ZERO(oST_ZERO),
        .oSECTOR(oSECTOR), .oROM_ADDR(oROM_ADDR),
        .oRD_EN(oRD_EN), .oRD_ADDR(oRD_ADDR),
        .oWR_EN(oWR_EN), .oWR_ADDR(oWR_ADDR),
        .oBANK_SEL(oBANK_SEL), .oSTAGE(oSTAGE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic                 st_zero;
        logic [A_BIT-1:0]     sector;
        logic [A_BIT-1:0]     rom;
        logic                 rd_en;
        logic [A_BIT-1:0]     rd_addr;
        logic                 wr_en;
        logic [A_BIT-1:0]     wr_addr;
        logic                 bank;
        logic [STAGE_BIT-1:0] stage;
    } obs_t;

    typedef struct {
        int   cyc;
        logic start;
        obs_t exp;
    } vec_t;

    vec_t vecs [NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: when the current transform was accepted, plus held outputs.
    int   cyc;
    int   run_start;
    obs_t m_prev, hist1, hist2;

    function automatic obs_t sample();
        obs_t o;
        o.busy = oBUSY;   o.done = oDONE;     o.st_zero = oST_ZERO;
        o.sector = oSECTOR; o.rom = oROM_ADDR;
        o.rd_en = oRD_EN; o.rd_addr = oRD_ADDR;
        o.wr_en = oWR_EN; o.wr_addr = oWR_ADDR;
        o.bank = oBANK_SEL; o.stage = oSTAGE;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("busy=%0b done=%0b stz=%0b sec=%0d rom=%0d rd=%0b/%0d wr=%0b/%0d bank=%0b stage=%0d",
                         o.busy, o.done, o.st_zero, o.sector, o.rom, o.rd_en, o.rd_addr,
                         o.wr_en, o.wr_addr, o.bank, o.stage);
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @t=%0t: got {%s} want {%s}", name, $time, fmt(got), fmt(want));
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_prev    = '0;
        hist1     = '0;
        hist2     = '0;
        run_start = -1000;
        cyc       = -1;
    endtask

    // Expected outputs after edge `cyc`, from the stage period arithmetic.
    task automatic model_edge(input logic start_in, output obs_t e);
        int k, s, j, sb;
        k = cyc - run_start;
        e = m_prev;
        e.rd_en = 1'b0; e.st_zero = 1'b0; e.done = 1'b0; e.busy = 1'b0;
        if (k >= 1 && k <= BUSY_CYC) begin
            s = (k - 1) / PER;
            j = (k - 1) % PER;
            e.busy  = 1'b1;
            e.stage = STAGE_BIT'(s);
            e.bank  = (s % 2) == 1;
            if (j < W) begin
                sb        = (s < A_BIT) ? s : A_BIT;
                e.rd_en   = 1'b1;
                e.rd_addr = A_BIT'(j);
                e.st_zero = (s == 0);
                e.sector  = A_BIT'(j % (1 << sb));
                e.rom     = A_BIT'((j % (1 << sb)) * (1 << (A_BIT - sb)));
            end
        end
        if (k == BUSY_CYC + 1) e.done = 1'b1;
        if (start_in && cyc >= run_start + BUSY_CYC + 2) begin
            run_start = cyc;
            e.stage   = '0;
            e.bank    = 1'b0;
        end
        e.wr_en   = hist2.rd_en;
        e.wr_addr = hist2.rd_addr;
        hist2  = hist1;
        hist1  = e;
        m_prev = e;
    endtask

    task automatic tick(input logic st, output obs_t got);
        obs_t exp;
        iSTART = st;
        @(posedge iCLK);
        cyc = cyc + 1;
        model_edge(st, exp);
        #1;
        got = sample();
        check_obs("model", got, exp);
    endtask

    task automatic async_reset();
        #2;
        iSTART = 1'b0;
        iRESET = 1'b0;
        #1;
        check_obs("async_reset", sample(), '0);
        @(posedge iCLK);
        #1;
        check_obs("reset_hold", sample(), '0);
        @(negedge iCLK);
        iRESET = 1'b1;
        model_reset();
    endtask

    function automatic vec_t mk(int c, logic st, logic busy, logic done, logic stz, int sec, int rom,
                                logic rden, int rda, logic wren, int wra, logic bank, int stage);
        vec_t v;
        v.cyc = c;
        v.start = st;
        v.exp.busy = busy; v.exp.done = done; v.exp.st_zero = stz;
        v.exp.sector = A_BIT'(sec); v.exp.rom = A_BIT'(rom);
        v.exp.rd_en = rden; v.exp.rd_addr = A_BIT'(rda);
        v.exp.wr_en = wren; v.exp.wr_addr = A_BIT'(wra);
        v.exp.bank = bank; v.exp.stage = STAGE_BIT'(stage);
        return v;
    endfunction

    function automatic logic start_for(int c);
        for (int i = 0; i < NV; i++)
            if (vecs[i].cyc == c) return vecs[i].start;
        return 1'b0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t got;
        int   wr_n, busy_first, busy_last, done_n, done_at, rise_at;
        logic prev_busy;

        if (LAST_STAGE >= (1 << STAGE_BIT)) begin
            $display("FAIL param_range: LAST_STAGE=%0d does not fit STAGE_BIT=%0d", LAST_STAGE, STAGE_BIT);
            $fatal(1, "param range");
        end

        //              cyc st  bsy dn stz sec rom rd rda wr wra bk stg
        vecs[0]  = mk(  0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0,  0, 0);
        vecs[1]  = mk(  1, 0,  1, 0, 1,  0,  0, 1, 0,  0, 0,  0, 0);
        vecs[2]  = mk(  3, 0,  1, 0, 1,  0,  0, 1, 2,  1, 0,  0, 0);
        vecs[3]  = mk(  8, 0,  1, 0, 1,  0,  0, 1, 7,  1, 5,  0, 0);
        vecs[4]  = mk(  9, 0,  1, 0, 0,  0,  0, 0, 7,  1, 6,  0, 0);
        vecs[5]  = mk( 10, 0,  1, 0, 0,  0,  0, 0, 7,  1, 7,  0, 0);
        vecs[6]  = mk( 11, 0,  1, 0, 0,  0,  0, 1, 0,  0, 7,  1, 1);
        vecs[7]  = mk( 12, 0,  1, 0, 0,  1,  4, 1, 1,  0, 7,  1, 1);
        vecs[8]  = mk( 13, 0,  1, 0, 0,  0,  0, 1, 2,  1, 0,  1, 1);
        vecs[9]  = mk( 18, 0,  1, 0, 0,  1,  4, 1, 7,  1, 5,  1, 1);
        vecs[10] = mk( 20, 1,  1, 0, 0,  1,  4, 0, 7,  1, 7,  1, 1);
        vecs[11] = mk( 21, 0,  1, 0, 0,  0,  0, 1, 0,  0, 7,  0, 2);
        vecs[12] = mk( 24, 0,  1, 0, 0,  3,  6, 1, 3,  1, 1,  0, 2);
        vecs[13] = mk( 28, 0,  1, 0, 0,  3,  6, 1, 7,  1, 5,  0, 2);
        vecs[14] = mk( 33, 0,  1, 0, 0,  2,  2, 1, 2,  1, 0,  1, 3);
        vecs[15] = mk( 41, 0,  1, 0, 0,  0,  0, 1, 0,  0, 7,  0, 4);
        vecs[16] = mk( 44, 0,  1, 0, 0,  3,  3, 1, 3,  1, 1,  0, 4);
        vecs[17] = mk( 48, 0,  1, 0, 0,  7,  7, 1, 7,  1, 5,  0, 4);
        vecs[18] = mk( 50, 0,  1, 0, 0,  7,  7, 0, 7,  1, 7,  0, 4);
        vecs[19] = mk( 51, 0,  0, 1, 0,  7,  7, 0, 7,  0, 7,  0, 4);
        vecs[20] = mk( 52, 0,  0, 0, 0,  7,  7, 0, 7,  0, 7,  0, 4);

        iRESET = 1'b0;
        iSTART = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        check_obs("reset_state", sample(), '0);
        @(negedge iCLK);
        iRESET = 1'b1;
        model_reset();

        // Full directed run; the pulse at cycle 20 must be ignored.
        wr_n = 0; busy_first = -1; busy_last = -1; done_n = 0; done_at = -1;
        for (int rel = 0; rel <= 56; rel++) begin
            tick((rel == 0) ? 1'b1 : start_for(rel - 1), got);
            if (got.wr_en) wr_n++;
            if (got.busy) begin
                if (busy_first < 0) busy_first = rel;
                busy_last = rel;
            end
            if (got.done) begin
                done_n++;
                done_at = rel;
            end
            for (int i = 0; i < NV; i++)
                if (vecs[i].cyc == rel) check_obs($sformatf("vec_c%0d", rel), got, vecs[i].exp);
        end
        check_int("write_count", wr_n, 40);
        check_int("busy_first", busy_first, 1);
        check_int("busy_last", busy_last, 50);
        check_int("done_count", done_n, 1);
        check_int("done_cycle", done_at, 51);

        // Reset in the middle of stage 2, then restart from stage 0.
        tick(1'b1, got);
        for (int rel = 1; rel <= 25; rel++) tick(1'b0, got);
        async_reset();
        wr_n = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, got);
            if (got.wr_en) wr_n++;
        end
        check_int("no_write_after_reset", wr_n, 0);
        tick(1'b1, got);
        for (int rel = 1; rel <= 57; rel++) begin
            tick(1'b0, got);
            if (rel == 1) begin
                check_int("restart_stage", int'(got.stage), 0);
                check_int("restart_st_zero", int'(got.st_zero), 1);
            end
        end

        // iSTART held high: second busy window opens at cycle 53.
        rise_at = -1;
        prev_busy = 1'b0;
        for (int rel = 0; rel <= 115; rel++) begin
            tick(1'b1, got);
            if (got.busy && !prev_busy && rel > 1 && rise_at < 0) rise_at = rel;
            prev_busy = got.busy;
        end
        check_int("back_to_back_rise", rise_at, 53);
        for (int i = 0; i < 60; i++) tick(1'b0, got);

        // Random start pulses with occasional asynchronous resets.
        for (int i = 0; i < 700; i++) begin
            tick($urandom_range(0, 7) == 0, got);
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
